// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg
// Shared definitions for the memory bus controller:
//   state_t : controller FSM encodings (IDLE=0, WAIT=1, ACCESS=2, DONE=3)
//   WAIT_W  : width of each per-bank wait-state field
//   TMO_W   : width of the ACCESS timeout counter
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WAIT_W = 4;
    localparam int TMO_W  = 8;

endpackage

// File: rtl/memory_bus_timer.sv
// memory_bus_timer
// Loadable down-counter that paces the WAIT state.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset, clears the count
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one (saturates at zero)
//   o_last     : count currently equals 1 (final wait cycle)
module memory_bus_timer
    import memory_bus_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/memory_bus_ctrl.sv
// memory_bus_ctrl
// Single-master controller that routes CPU requests to one of NUM_BANKS
// banks selected by the top address bits, with per-bank wait states and a
// timeout on slow banks.
// Ports:
//   clk, reset        : clock and asynchronous active-low reset
//   address, data_in, write_mask, write_enable, bus_enable : CPU request
//   data_out, ready, error : CPU completion (ready is a one-cycle pulse)
//   bank_enable, bank_address, bank_data_in, bank_write_mask,
//   bank_write_enable : latched request presented to the banks
//   bank_data_out, bank_ready : bank read data slices and completions
module memory_bus_ctrl
    import memory_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_BITS  = 2,
    parameter logic [WAIT_W*(2**BANK_BITS)-1:0] BANK_WAIT = '0,
    parameter int TIMEOUT    = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDR_WIDTH-1:0]                 address,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic [DATA_WIDTH/8-1:0]               write_mask,
    input  logic                                  write_enable,
    input  logic                                  bus_enable,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  ready,
    output logic                                  error,
    output logic [(2**BANK_BITS)-1:0]             bank_enable,
    output logic [ADDR_WIDTH-BANK_BITS-1:0]       bank_address,
    output logic [DATA_WIDTH-1:0]                 bank_data_in,
    output logic [DATA_WIDTH/8-1:0]               bank_write_mask,
    output logic                                  bank_write_enable,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]  bank_data_out,
    input  logic [(2**BANK_BITS)-1:0]             bank_ready
);

    localparam int NUM_BANKS = 2**BANK_BITS;
    localparam int LOW_W     = ADDR_WIDTH - BANK_BITS;

    state_t                   r_state;
    logic [LOW_W-1:0]         r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [DATA_WIDTH/8-1:0]  r_mask;
    logic                     r_we;
    logic [BANK_BITS-1:0]     r_bank;
    logic [TMO_W-1:0]         r_tmo;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic                     r_ready;
    logic                     r_error;
    logic [NUM_BANKS-1:0]     r_bank_en;
    logic                     r_bank_we;

    logic [BANK_BITS-1:0]     w_bank;
    logic [WAIT_W-1:0]        w_bank_wait;
    logic                     w_accept;
    logic                     w_wait_last;
    logic [DATA_WIDTH-1:0]    w_rdata;

    assign w_bank      = address[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_bank_wait = BANK_WAIT[w_bank*WAIT_W +: WAIT_W];
    assign w_accept    = (r_state == IDLE) && bus_enable;
    assign w_rdata     = bank_data_out[r_bank*DATA_WIDTH +: DATA_WIDTH];

    memory_bus_timer #(.W(WAIT_W)) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_bank_wait),
        .i_dec      (r_state == WAIT),
        .o_last     (w_wait_last)
    );

    // Bank strobes are registered on the transition into ACCESS and dropped
    // on the transition out, so they are high exactly during ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_we       <= 1'b0;
            r_bank     <= '0;
            r_tmo      <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_bank_en  <= '0;
            r_bank_we  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_enable) begin
                        r_addr <= address[LOW_W-1:0];
                        r_data <= data_in;
                        r_mask <= write_mask;
                        r_we   <= write_enable;
                        r_bank <= w_bank;
                        if (w_bank_wait != '0) begin
                            r_state <= WAIT;
                        end else begin
                            r_state   <= ACCESS;
                            r_tmo     <= '0;
                            r_bank_en <= NUM_BANKS'(1) << w_bank;
                            r_bank_we <= write_enable;
                        end
                    end
                end
                WAIT: begin
                    if (w_wait_last) begin
                        r_state   <= ACCESS;
                        r_tmo     <= '0;
                        r_bank_en <= NUM_BANKS'(1) << r_bank;
                        r_bank_we <= r_we;
                    end
                end
                ACCESS: begin
                    // bank_ready is checked first so it wins a tie with timeout
                    if (bank_ready[r_bank]) begin
                        if (!r_we) r_data_out <= w_rdata;
                        r_error   <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= DONE;
                        r_bank_en <= '0;
                        r_bank_we <= 1'b0;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_data_out <= '1;
                        r_error    <= 1'b1;
                        r_ready    <= 1'b1;
                        r_state    <= DONE;
                        r_bank_en  <= '0;
                        r_bank_we  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out          = r_data_out;
    assign ready             = r_ready;
    assign error             = r_error;
    assign bank_enable       = r_bank_en;
    assign bank_address      = r_addr;
    assign bank_data_in      = r_data;
    assign bank_write_mask   = r_mask;
    assign bank_write_enable = r_bank_we;

endmodule

// File: tb/tb_memory_bus_ctrl.sv
module tb_memory_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  address;
    logic [31:0]  data_in;
    logic [3:0]   write_mask;
    logic         write_enable;
    logic         bus_enable;
    logic [31:0]  data_out;
    logic         ready;
    logic         error;
    logic [3:0]   bank_enable;
    logic [13:0]  bank_address;
    logic [31:0]  bank_data_in;
    logic [3:0]   bank_write_mask;
    logic         bank_write_enable;
    logic [127:0] bank_data_out;
    logic [3:0]   bank_ready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] S0 = 32'h0BAD0000;
    localparam logic [31:0] S1 = 32'h11112222;
    localparam logic [31:0] S2 = 32'hCAFEF00D;
    localparam logic [31:0] S3 = 32'h12345678;

    memory_bus_ctrl #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .BANK_BITS(2),
        .BANK_WAIT(16'h0003), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_mask(write_mask), .write_enable(write_enable),
        .bus_enable(bus_enable), .data_out(data_out), .ready(ready),
        .error(error), .bank_enable(bank_enable), .bank_address(bank_address),
        .bank_data_in(bank_data_in), .bank_write_mask(bank_write_mask),
        .bank_write_enable(bank_write_enable), .bank_data_out(bank_data_out),
        .bank_ready(bank_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({data_out, ready, error, bank_enable, bank_write_enable} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {data_out, ready, error, bank_enable, bank_write_enable});
        end
        n_checks++;
        if ({bank_address, bank_data_in, bank_write_mask} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset_latches got=%h want=0",
                     {bank_address, bank_data_in, bank_write_mask});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_min();
        bank_ready   = 4'hF;
        address      = 16'hC004;
        write_enable = 1'b0;
        bus_enable   = 1'b1;
        tick();
        bus_enable = 1'b0;
        n_checks++;
        if (bank_enable !== 4'b1000 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_min_access got en=%b rdy=%b want en=1000 rdy=0", bank_enable, ready);
        end
        n_checks++;
        if (bank_address !== 14'h0004) begin
            n_fail++;
            $display("FAIL read_min_addr got=%h want=0004", bank_address);
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || data_out !== S3 || error !== 1'b0 || bank_enable !== 4'b0) begin
            n_fail++;
            $display("FAIL read_min_done got rdy=%b d=%h err=%b en=%b want 1 %h 0 0000",
                     ready, data_out, error, bank_enable, S3);
        end
        tick();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_min_pulse got rdy=%b want 0", ready);
        end
    endtask

    task automatic test_write_wait();
        address      = 16'h0010;
        data_in      = 32'hAABBCCDD;
        write_mask   = 4'b0011;
        write_enable = 1'b1;
        bus_enable   = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            bus_enable = 1'b0;
            n_checks++;
            if (bank_enable !== 4'b0 || bank_write_enable !== 1'b0 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_wait_%0d got en=%b we=%b rdy=%b want 0000 0 0",
                         t, bank_enable, bank_write_enable, ready);
            end
        end
        tick();
        n_checks++;
        if (bank_enable !== 4'b0001 || bank_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL write_access got en=%b we=%b want 0001 1", bank_enable, bank_write_enable);
        end
        n_checks++;
        if (bank_address !== 14'h0010 || bank_data_in !== 32'hAABBCCDD || bank_write_mask !== 4'b0011) begin
            n_fail++;
            $display("FAIL write_latch got a=%h d=%h m=%b want 0010 aabbccdd 0011",
                     bank_address, bank_data_in, bank_write_mask);
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || data_out !== S3 || bank_write_enable !== 1'b0 || bank_enable !== 4'b0) begin
            n_fail++;
            $display("FAIL write_done got rdy=%b d=%h we=%b en=%b want 1 %h 0 0000",
                     ready, data_out, bank_write_enable, bank_enable, S3);
        end
        tick();
        write_enable = 1'b0;
    endtask

    task automatic test_timeout();
        bank_ready = 4'b1011;
        address    = 16'h8000;
        bus_enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            bus_enable = 1'b0;
            n_checks++;
            if (bank_enable !== 4'b0100 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_access_%0d got en=%b rdy=%b want 0100 0", t, bank_enable, ready);
            end
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || error !== 1'b1 || data_out !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL timeout_done got rdy=%b err=%b d=%h want 1 1 ffffffff", ready, error, data_out);
        end
        tick();
        n_checks++;
        if (ready !== 1'b0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error_hold got rdy=%b err=%b want 0 1", ready, error);
        end
        bank_ready = 4'hF;
        bus_enable = 1'b1;
        tick();
        bus_enable = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b1 || error !== 1'b0 || data_out !== S2) begin
            n_fail++;
            $display("FAIL timeout_clear got rdy=%b err=%b d=%h want 1 0 %h", ready, error, data_out, S2);
        end
        tick();
    endtask

    task automatic test_ready_on_last();
        bank_ready = 4'b1101;
        address    = 16'h4000;
        bus_enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            bus_enable = 1'b0;
        end
        bank_ready = 4'hF;
        tick();
        n_checks++;
        if (ready !== 1'b1 || error !== 1'b0 || data_out !== S1) begin
            n_fail++;
            $display("FAIL ready_on_last got rdy=%b err=%b d=%h want 1 0 %h", ready, error, data_out, S1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses     = 0;
        address    = 16'hC000;
        bus_enable = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (ready === 1'b1) pulses++;
            n_checks++;
            if (ready !== (t % 3 == 2) || bank_enable !== ((t % 3 == 1) ? 4'b1000 : 4'b0000)) begin
                n_fail++;
                $display("FAIL b2b_zero_%0d got rdy=%b en=%b want %b %b", t, ready, bank_enable,
                         (t % 3 == 2), ((t % 3 == 1) ? 4'b1000 : 4'b0000));
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses got=%0d want=3", pulses);
        end
        bus_enable = 1'b0;
        tick();
        // bank0 has 3 wait states: IDLE visit, 3 WAIT, ACCESS, DONE per request
        address    = 16'h0000;
        bus_enable = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_checks++;
            if (ready !== (t % 6 == 5) || bank_enable !== ((t % 6 == 4) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL b2b_wait_%0d got rdy=%b en=%b want %b %b", t, ready, bank_enable,
                         (t % 6 == 5), ((t % 6 == 4) ? 4'b0001 : 4'b0000));
            end
        end
        bus_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        stray      = 0;
        address    = 16'h0020;
        data_in    = 32'h55667788;
        write_mask = 4'b1111;
        bus_enable = 1'b1;
        tick();
        bus_enable = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({data_out, ready, error, bank_enable, bank_write_enable} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got=%h want=0",
                     {data_out, ready, error, bank_enable, bank_write_enable});
        end
        n_checks++;
        if ({bank_address, bank_data_in, bank_write_mask} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset_mid_latches got=%h want=0",
                     {bank_address, bank_data_in, bank_write_mask});
        end
        tick();
        reset = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (ready !== 1'b0 || bank_enable !== 4'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_ready got=%0d stray cycles want=0", stray);
        end
        bus_enable = 1'b1;
        address    = 16'hC000;
        tick();
        bus_enable = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b1 || data_out !== S3) begin
            n_fail++;
            $display("FAIL reset_mid_recover got rdy=%b d=%h want 1 %h", ready, data_out, S3);
        end
    endtask

    initial begin
        reset         = 1'b1;
        address       = '0;
        data_in       = '0;
        write_mask    = '0;
        write_enable  = 1'b0;
        bus_enable    = 1'b0;
        bank_ready    = 4'hF;
        bank_data_out = {S3, S2, S1, S0};
        #1;
        test_reset();
        test_read_min();
        test_write_wait();
        test_timeout();
        test_ready_on_last();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_bus_ctrl.md
MEMORY_BUS_CTRL -- requirements
Module: memory_bus_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- ADDR_WIDTH, 16: CPU address width.
- DATA_WIDTH, 32: data width; a multiple of 8.
- BANK_BITS, 2: top address bits selecting the bank; NUM_BANKS = 2**BANK_BITS.
- BANK_WAIT, 0: packed NUM_BANKS x 4-bit wait-state count per bank; bank i uses bits [4i+3:4i].
- TIMEOUT, 255: maximum cycles in ACCESS before an error completion; range 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state is updated on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- address, in, ADDR_WIDTH: CPU address.
- data_in, in, DATA_WIDTH: CPU write data.
- write_mask, in, DATA_WIDTH/8: byte-lane enables; 1 = lane written.
- write_enable, in, 1: 1 = write, 0 = read.
- bus_enable, in, 1: request strobe.
- data_out, out, DATA_WIDTH: registered read data.
- ready, out, 1: one-cycle completion pulse.
- error, out, 1: timeout flag, valid while ready is high.
- bank_enable, out, NUM_BANKS: one-hot access strobe.
- bank_address, out, ADDR_WIDTH-BANK_BITS: latched low address.
- bank_data_in, out, DATA_WIDTH: latched write data.
- bank_write_mask, out, DATA_WIDTH/8: latched mask.
- bank_write_enable, out, 1: latched write flag, gated by the access.
- bank_data_out, in, NUM_BANKS*DATA_WIDTH: read data; bank i occupies slice i.
- bank_ready, in, NUM_BANKS: per-bank completion from slow devices (SPI EEPROM etc.); tie high for block RAM.

Function
REQ-003 The FSM SHALL have four states: IDLE, WAIT, ACCESS, DONE.
REQ-004 In IDLE, when bus_enable is sampled high, the block SHALL latch:
- address, data_in, write_mask and write_enable;
- bank = address[ADDR_WIDTH-1 -: BANK_BITS].
REQ-005 From IDLE, the FSM SHALL go to WAIT with the wait counter loaded to BANK_WAIT[bank] if that value is nonzero, else directly to ACCESS.
REQ-006 WAIT SHALL decrement the wait counter each cycle and move to ACCESS on the cycle after the counter reaches 1, giving exactly BANK_WAIT[bank] cycles in WAIT.
REQ-007 In ACCESS, bank_enable[bank] SHALL be high and all other bank_enable bits low.
REQ-008 In ACCESS, bank_write_enable SHALL equal the latched write flag; outside ACCESS, bank_enable and bank_write_enable SHALL be 0.
REQ-009 In ACCESS, when bank_ready[bank] is sampled high, data_out SHALL load the selected slice of bank_data_out (reads only; writes leave data_out unchanged), error SHALL be cleared, and the FSM SHALL go to DONE.
REQ-010 A timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; if it reaches TIMEOUT without bank_ready, the FSM SHALL go to DONE with error=1 and data_out set to all ones.
REQ-011 If bank_ready arrives on the same cycle the timeout counter reaches TIMEOUT, bank_ready SHALL win (normal completion, error=0).
REQ-012 ready SHALL be 1 exactly while in DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-013 Minimum latency (zero wait states, bank_ready already high) SHALL be ready high 2 cycles after bus_enable is sampled.
REQ-014 bus_enable SHALL be ignored outside IDLE; a request held high through DONE SHALL be accepted again on the cycle the FSM is in IDLE.
REQ-015 bank_address, bank_data_in and bank_write_mask SHALL stay stable from latch until return to IDLE.
REQ-016 error SHALL hold its value until the next completion.

Reset
REQ-017 On reset low, asynchronously:
- state=IDLE;
- counters=0;
- data_out=0, ready=0, error=0;
- bank_enable=0, bank_write_enable=0;
- latched address, data and mask=0.
REQ-018 Reset asserted mid-transaction SHALL abort it; no ready pulse SHALL follow reset release without a new request.

Structure
REQ-019 Package memory_bus_pkg SHALL hold:
- the state encodings (IDLE=0, WAIT=1, ACCESS=2, DONE=3);
- the wait-field width (4);
- the timeout counter width (8).
REQ-020 One sub-module, memory_bus_timer, SHALL implement the loadable down-counter used for WAIT; the timeout counter stays inline.

Verification
REQ-021 Read, bank 3, BANK_WAIT=0, bank_ready=1111, bank3 data 0x12345678 -> ready pulses 2 cycles after request, data_out=0x12345678, error=0.
REQ-022 Write to 0x0010, mask 0011, data 0xAABBCCDD, bank0 wait=3 -> bank_enable=0001 after exactly 3 WAIT cycles, bank_write_enable=1, bank_address=0x0010, ready 1 cycle later.
REQ-023 Read bank 2, bank_ready[2] held low, TIMEOUT=8 -> ready with error=1 and data_out=0xFFFFFFFF after 8 ACCESS cycles; the following normal read clears error.
REQ-024 bank_ready[1] rises on the 8th ACCESS cycle, TIMEOUT=8 -> normal completion, error=0.
REQ-025 bus_enable held high continuously -> one transaction per IDLE visit; no request accepted in WAIT, ACCESS or DONE.
REQ-026 Reset pulsed low during WAIT -> all outputs 0 immediately; no ready after reset release until a new request.
